// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D-cache block fills over one pipelined memory port.
// D-cache wins ties; each grant issues and collects a full block.
module cache_fill_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W = 16,
  localparam int WW = $clog2(WORDS_PER_BLOCK),
  localparam int OFF = WW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_miss_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_miss_addr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_valid,
  input  logic [15:0]       mem_data,
  output logic [15:0]       fill_data,
  output logic [WW-1:0]     fill_word,
  output logic              icache_fill_we,
  output logic              dcache_fill_we,
  output logic              icache_tag_we,
  output logic              dcache_tag_we,
  output logic              fill_busy,
  output logic              fill_owner
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam logic [WW-1:0] LAST = WW'(WORDS_PER_BLOCK - 1);

  state_t            state_q;
  logic [WW-1:0]     issue_q;
  logic [WW-1:0]     ret_q;
  logic              owner_q;
  logic              mem_en_q;
  logic              busy_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [ADDR_W-1:0] i_base;
  logic [ADDR_W-1:0] d_base;
  logic              ret_fire;
  logic              tag_fire;

  assign i_base = {icache_miss_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign d_base = {dcache_miss_addr[ADDR_W-1:OFF], {OFF{1'b0}}};

  // Returns only count while a fill owns the port; stale data is dropped.
  assign ret_fire = mem_data_valid && (state_q != IDLE);
  assign tag_fire = ret_fire && (ret_q == LAST);

  assign fill_data      = mem_data;
  assign fill_word      = ret_q;
  assign icache_fill_we = ret_fire && !owner_q;
  assign dcache_fill_we = ret_fire && owner_q;
  assign icache_tag_we  = tag_fire && !owner_q;
  assign dcache_tag_we  = tag_fire && owner_q;

  assign mem_en     = mem_en_q;
  assign mem_addr   = mem_addr_q;
  assign fill_busy  = busy_q;
  assign fill_owner = owner_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      issue_q    <= '0;
      ret_q      <= '0;
      owner_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dcache_miss || icache_miss) begin
            owner_q    <= dcache_miss;
            mem_addr_q <= dcache_miss ? d_base : i_base;
            mem_en_q   <= 1'b1;
            busy_q     <= 1'b1;
            issue_q    <= '0;
            ret_q      <= '0;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_q == LAST) begin
            mem_en_q <= 1'b0;
            state_q  <= DRAIN;
          end else begin
            mem_addr_q <= mem_addr_q + ADDR_W'(2);
            issue_q    <= issue_q + WW'(1);
          end
        end
        DRAIN: ;
        default: state_q <= IDLE;
      endcase
      if (ret_fire) ret_q <= ret_q + WW'(1);
      // Final return closes the fill even if issue has not finished.
      if (tag_fire) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        mem_en_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: fixed-latency memory, schedule-based model,
// per-cycle compare plus hand-computed cycle expectations.
module tb_cache_fill_arbiter;

  localparam int W    = 8;
  localparam int L    = 4;
  localparam int MAXC = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_miss = 1'b0;
  logic [15:0] icache_miss_addr = '0;
  logic        dcache_miss = 1'b0;
  logic [15:0] dcache_miss_addr = '0;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data = '0;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        icache_fill_we;
  logic        dcache_fill_we;
  logic        icache_tag_we;
  logic        dcache_tag_we;
  logic        fill_busy;
  logic        fill_owner;

  int nchecks = 0;
  int nerrors = 0;
  int cyc = 0;
  int free_at = 0;
  int t0 = 0;
  bit chk_on = 1'b0;
  bit inject = 1'b0;

  bit        exp_en   [MAXC];
  bit [15:0] exp_addr [MAXC];
  bit        exp_ifw  [MAXC];
  bit        exp_dfw  [MAXC];
  bit        exp_itag [MAXC];
  bit        exp_dtag [MAXC];
  bit [2:0]  exp_word [MAXC];
  bit [15:0] exp_data [MAXC];
  bit        exp_busy [MAXC];
  bit        exp_own  [MAXC];
  bit        ret_v    [MAXC];
  bit [15:0] ret_a    [MAXC];

  always #5 clk = ~clk;

  cache_fill_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .icache_miss      (icache_miss),
    .icache_miss_addr (icache_miss_addr),
    .dcache_miss      (dcache_miss),
    .dcache_miss_addr (dcache_miss_addr),
    .mem_en           (mem_en),
    .mem_addr         (mem_addr),
    .mem_data_valid   (mem_data_valid),
    .mem_data         (mem_data),
    .fill_data        (fill_data),
    .fill_word        (fill_word),
    .icache_fill_we   (icache_fill_we),
    .dcache_fill_we   (dcache_fill_we),
    .icache_tag_we    (icache_tag_we),
    .dcache_tag_we    (dcache_tag_we),
    .fill_busy        (fill_busy),
    .fill_owner       (fill_owner)
  );

  function automatic logic [15:0] mdat(logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_from(int c0);
    for (int c = c0; c < MAXC; c++) begin
      exp_en[c]   = 0;
      exp_ifw[c]  = 0;
      exp_dfw[c]  = 0;
      exp_itag[c] = 0;
      exp_dtag[c] = 0;
      exp_word[c] = 0;
      exp_busy[c] = 0;
      exp_own[c]  = 0;
    end
  endtask

  // A grant decided at the end of cycle t fixes the whole fill schedule.
  task automatic grant(int t, bit o, logic [15:0] a);
    logic [15:0] base;
    int n;
    int r;
    base = a & 16'hFFF0;
    for (int c = t + 1; c < MAXC; c++) exp_own[c] = o;
    for (int c = t + 1; c <= t + W + L && c < MAXC; c++) begin
      exp_busy[c] = 1;
      n = c - (t + 1 + L);
      if (n < 0) n = 0;
      if (n > W) n = W;
      exp_word[c] = 3'(n % W);
    end
    for (int k = 0; k < W; k++) begin
      if (t + 1 + k < MAXC) begin
        exp_en[t + 1 + k]   = 1;
        exp_addr[t + 1 + k] = base + 16'(2 * k);
      end
      r = t + 1 + k + L;
      if (r < MAXC) begin
        if (o) exp_dfw[r] = 1;
        else exp_ifw[r] = 1;
        exp_data[r] = mdat(base + 16'(2 * k));
      end
    end
    r = t + W + L;
    if (r < MAXC) begin
      if (o) exp_dtag[r] = 1;
      else exp_itag[r] = 1;
    end
    free_at = t + W + L + 1;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      clear_from(cyc + 1);
      free_at = cyc + 1;
    end else if (cyc >= free_at && dcache_miss) begin
      grant(cyc, 1'b1, dcache_miss_addr);
    end else if (cyc >= free_at && icache_miss) begin
      grant(cyc, 1'b0, icache_miss_addr);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (mem_en === 1'b1 && cyc + L < MAXC) begin
      ret_v[cyc + L] = 1;
      ret_a[cyc + L] = mem_addr;
    end
  end

  // Memory return path and cache-side miss release after a tag write.
  always @(posedge clk) begin
    #3;
    if (cyc > 0 && cyc <= MAXC && exp_itag[cyc - 1]) icache_miss = 1'b0;
    if (cyc > 0 && cyc <= MAXC && exp_dtag[cyc - 1]) dcache_miss = 1'b0;
    if (cyc < MAXC && ret_v[cyc]) begin
      mem_data_valid = 1'b1;
      mem_data       = mdat(ret_a[cyc]);
    end else if (inject) begin
      mem_data_valid = 1'b1;
      mem_data       = 16'hBEEF;
    end else begin
      mem_data_valid = 1'b0;
      mem_data       = 16'h0000;
    end
  end

  always @(negedge clk) begin
    if (chk_on && cyc < MAXC) begin
      cmp("mem_en", mem_en, exp_en[cyc]);
      if (exp_en[cyc]) cmp("mem_addr", mem_addr, exp_addr[cyc]);
      cmp("icache_fill_we", icache_fill_we, exp_ifw[cyc]);
      cmp("dcache_fill_we", dcache_fill_we, exp_dfw[cyc]);
      cmp("icache_tag_we", icache_tag_we, exp_itag[cyc]);
      cmp("dcache_tag_we", dcache_tag_we, exp_dtag[cyc]);
      cmp("fill_word", fill_word, exp_word[cyc]);
      cmp("fill_busy", fill_busy, exp_busy[cyc]);
      cmp("fill_owner", fill_owner, exp_own[cyc]);
      if (exp_ifw[cyc] || exp_dfw[cyc])
        cmp("fill_data", fill_data, exp_data[cyc]);
    end
  end

  task automatic go(int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic at(int c);
    do @(negedge clk); while (cyc < c);
  endtask

  initial begin
    @(posedge clk);
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_mem_en", mem_en, 1'b0);
    cmp("rst_mem_addr", mem_addr, 16'h0000);
    cmp("rst_busy", fill_busy, 1'b0);
    cmp("rst_owner", fill_owner, 1'b0);
    cmp("rst_word", fill_word, 3'd0);
    go(cyc + 1);
    rst_n = 1'b1;

    // I-miss only
    go(cyc + 1);
    t0 = cyc;
    icache_miss = 1'b1;
    icache_miss_addr = 16'h1236;
    at(t0 + 1);  cmp("t1_addr_first", mem_addr, 16'h1230);
    at(t0 + 5);  cmp("t1_ifw_first", icache_fill_we, 1'b1);
    cmp("t1_word_first", fill_word, 3'd0);
    at(t0 + 8);  cmp("t1_addr_last", mem_addr, 16'h123E);
    at(t0 + 9);  cmp("t1_en_off", mem_en, 1'b0);
    at(t0 + 12); cmp("t1_itag", icache_tag_we, 1'b1);
    cmp("t1_word_last", fill_word, 3'd7);
    at(t0 + 13); cmp("t1_idle", fill_busy, 1'b0);
    go(t0 + 15);

    // Simultaneous I and D misses: D first
    t0 = cyc;
    icache_miss = 1'b1;
    icache_miss_addr = 16'h0040;
    dcache_miss = 1'b1;
    dcache_miss_addr = 16'h8008;
    at(t0 + 1);  cmp("t2_d_addr", mem_addr, 16'h8000);
    cmp("t2_d_owner", fill_owner, 1'b1);
    at(t0 + 8);  cmp("t2_d_last", mem_addr, 16'h800E);
    at(t0 + 12); cmp("t2_dtag", dcache_tag_we, 1'b1);
    at(t0 + 14); cmp("t2_i_en", mem_en, 1'b1);
    cmp("t2_i_addr", mem_addr, 16'h0040);
    cmp("t2_i_owner", fill_owner, 1'b0);
    go(t0 + 28);

    // D-miss arriving mid I fill
    t0 = cyc;
    icache_miss = 1'b1;
    icache_miss_addr = 16'h2000;
    go(t0 + 3);
    dcache_miss = 1'b1;
    dcache_miss_addr = 16'h3008;
    at(t0 + 4);  cmp("t3_i_addr", mem_addr, 16'h2006);
    cmp("t3_i_owner", fill_owner, 1'b0);
    at(t0 + 14); cmp("t3_d_addr", mem_addr, 16'h3000);
    cmp("t3_d_owner", fill_owner, 1'b1);
    go(t0 + 28);

    // Top-of-memory block
    t0 = cyc;
    dcache_miss = 1'b1;
    dcache_miss_addr = 16'hFFFA;
    at(t0 + 1);  cmp("t4_addr_first", mem_addr, 16'hFFF0);
    at(t0 + 8);  cmp("t4_addr_last", mem_addr, 16'hFFFE);
    go(t0 + 15);

    // Reset mid-fill, stale returns, then a fresh D fill
    t0 = cyc;
    icache_miss = 1'b1;
    icache_miss_addr = 16'h4444;
    go(t0 + 7);
    rst_n = 1'b0;
    icache_miss = 1'b0;
    go(t0 + 8);
    rst_n = 1'b1;
    at(t0 + 8);  cmp("t5_busy", fill_busy, 1'b0);
    cmp("t5_en", mem_en, 1'b0);
    at(t0 + 9);  cmp("t5_stale_ifw", icache_fill_we, 1'b0);
    go(t0 + 13);
    dcache_miss = 1'b1;
    dcache_miss_addr = 16'h5000;
    at(t0 + 14); cmp("t5_d_addr", mem_addr, 16'h5000);
    at(t0 + 18); cmp("t5_dfw", dcache_fill_we, 1'b1);
    cmp("t5_word", fill_word, 3'd0);
    go(t0 + 28);

    // Spurious return in IDLE
    t0 = cyc;
    inject = 1'b1;
    at(t0 + 1);  cmp("t6_ifw", icache_fill_we, 1'b0);
    cmp("t6_dfw", dcache_fill_we, 1'b0);
    cmp("t6_word", fill_word, 3'd0);
    cmp("t6_busy", fill_busy, 1'b0);
    go(t0 + 2);
    inject = 1'b0;
    go(t0 + 3);
    icache_miss = 1'b1;
    icache_miss_addr = 16'h6000;
    at(t0 + 8);  cmp("t6_fill_ifw", icache_fill_we, 1'b1);
    cmp("t6_fill_word", fill_word, 3'd0);
    go(t0 + 20);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
